// File: rtl/tile_coverage_scan.sv
`default_nettype none
// ============================================================================
// Module   : tile_coverage_scan
// Brief    : Walks a TILE_W x TILE_H tile row by row and emits one registered
//            three-edge coverage mask per row with valid/ready handshaking.
// Revision : 1.0
// ============================================================================
module tile_coverage_scan #(
    parameter int INT_W  = 20,
    parameter int SUBPIX = 4,
    parameter int W      = INT_W + SUBPIX + 1,
    parameter int TILE_W = 8,
    parameter int TILE_H = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [W-1:0]                         a0_i,
    input  logic [W-1:0]                         a1_i,
    input  logic [W-1:0]                         a2_i,
    input  logic [W-1:0]                         b0_i,
    input  logic [W-1:0]                         b1_i,
    input  logic [W-1:0]                         b2_i,
    input  logic [W-1:0]                         e0_init_i,
    input  logic [W-1:0]                         e1_init_i,
    input  logic [W-1:0]                         e2_init_i,
    input  logic                                 flush_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [TILE_W-1:0]                    out_mask_o,
    output logic [$clog2(TILE_H)-1:0]            out_row_o,
    output logic                                 out_last_o,
    output logic [$clog2(TILE_W*TILE_H+1)-1:0]   out_count_o
);
    localparam int RW = $clog2(TILE_H);
    localparam int CW = $clog2(TILE_W * TILE_H + 1);
    localparam int EW = W + $clog2((TILE_W > TILE_H) ? TILE_W : TILE_H) + 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(TILE_H - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic signed [EW-1:0]  a_q [3];
    logic signed [EW-1:0]  a_d [3];
    logic signed [EW-1:0]  b_q [3];
    logic signed [EW-1:0]  b_d [3];
    logic signed [EW-1:0]  erow_q [3];
    logic signed [EW-1:0]  erow_d [3];
    logic signed [EW-1:0]  a_in [3];
    logic signed [EW-1:0]  b_in [3];
    logic signed [EW-1:0]  e_in [3];
    logic [RW-1:0]         row_q, row_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         row_pop, row_total;
    logic [TILE_W-1:0]     row_mask;
    logic                  out_valid_d, out_last_d;
    logic [TILE_W-1:0]     out_mask_d;
    logic [RW-1:0]         out_row_d;
    logic [CW-1:0]         out_count_d;

    assign a_in[0] = EW'($signed(a0_i));
    assign a_in[1] = EW'($signed(a1_i));
    assign a_in[2] = EW'($signed(a2_i));
    assign b_in[0] = EW'($signed(b0_i));
    assign b_in[1] = EW'($signed(b1_i));
    assign b_in[2] = EW'($signed(b2_i));
    assign e_in[0] = EW'($signed(e0_init_i));
    assign e_in[1] = EW'($signed(e1_init_i));
    assign e_in[2] = EW'($signed(e2_init_i));

    // All pixels of the current row in parallel; k is a constant per column.
    for (genvar k = 0; k < TILE_W; k++) begin : g_px
        localparam logic signed [EW-1:0] K = EW'(k);
        logic [2:0] neg;
        for (genvar i = 0; i < 3; i++) begin : g_edge
            logic signed [EW-1:0] ev;
            assign ev     = erow_q[i] + K * a_q[i];
            assign neg[i] = ev[EW-1];
        end
        assign row_mask[k] = ~|neg;
    end

    always_comb begin
        row_pop = '0;
        for (int k = 0; k < TILE_W; k++) begin
            row_pop = row_pop + CW'(row_mask[k]);
        end
    end

    assign row_total  = cnt_q + row_pop;
    assign in_ready_o = (state_q == S_IDLE);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        erow_d      = erow_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_o;
        out_last_d  = out_last_o;
        out_mask_d  = out_mask_o;
        out_row_d   = out_row_o;
        out_count_d = out_count_o;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    erow_d  = e_in;
                    row_d   = '0;
                    cnt_d   = '0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                out_mask_d  = row_mask;
                out_row_d   = row_q;
                out_last_d  = (row_q == LAST_ROW);
                out_count_d = (row_q == LAST_ROW) ? row_total : '0;
                out_valid_d = 1'b1;
                cnt_d       = row_total;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    out_count_d = '0;
                    if (row_q == LAST_ROW) begin
                        state_d = S_IDLE;
                    end else begin
                        for (int i = 0; i < 3; i++) begin
                            erow_d[i] = erow_q[i] + b_q[i];
                        end
                        row_d   = row_q + 1'b1;
                        state_d = S_EMIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides any handshake in the same cycle, including an input accept.
        if (flush_i) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_mask_d  = '0;
            out_row_d   = '0;
            out_count_d = '0;
            cnt_d       = '0;
            row_d       = '0;
            a_d         = a_q;
            b_d         = b_q;
            erow_d      = erow_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            cnt_q       <= '0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            out_mask_o  <= '0;
            out_row_o   <= '0;
            out_count_o <= '0;
            for (int i = 0; i < 3; i++) begin
                a_q[i]    <= '0;
                b_q[i]    <= '0;
                erow_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            out_valid_o <= out_valid_d;
            out_last_o  <= out_last_d;
            out_mask_o  <= out_mask_d;
            out_row_o   <= out_row_d;
            out_count_o <= out_count_d;
            for (int i = 0; i < 3; i++) begin
                a_q[i]    <= a_d[i];
                b_q[i]    <= b_d[i];
                erow_q[i] <= erow_d[i];
            end
        end
    end

endmodule
`default_nettype wire
